// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family: read-mode encoding and
// pointer sizing helper.
package fifo_pkg;

  typedef enum logic {
    FIFO_MODE_STD  = 1'b0,
    FIFO_MODE_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DWIDTH register array: one synchronous write port and one
// asynchronous read port.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DWIDTH = 16
) (
  input  logic                         clk,
  input  logic                         i_wr_en,
  input  logic [ptr_width(DEPTH)-1:0]  i_wr_addr,
  input  logic [DWIDTH-1:0]            i_wr_data,
  input  logic [ptr_width(DEPTH)-1:0]  i_rd_addr,
  output logic [DWIDTH-1:0]            o_rd_data
);

  logic [DWIDTH-1:0] r_mem [DEPTH];

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost flags, error
// pulses and selectable standard / first-word-fall-through read mode.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int DWIDTH   = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [DWIDTH-1:0]           din,
  input  logic                        rd_en,
  output logic [DWIDTH-1:0]           dout,
  output logic                        dout_valid,
  output logic                        empty,
  output logic                        full,
  output logic                        almost_empty,
  output logic                        almost_full,
  output logic [ptr_width(DEPTH):0]   count,
  output logic                        wr_err,
  output logic                        rd_err
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);
  localparam bit            FWFT_ON  = (FWFT == int'(FIFO_MODE_FWFT));

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must be a power of 2 and >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_flags: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_flags: AE_LEVEL must be in 0..DEPTH-1");
  end
  if (FWFT != int'(FIFO_MODE_STD) && FWFT != int'(FIFO_MODE_FWFT)) begin : g_bad_mode
    $error("sync_fifo_flags: FWFT must be 0 or 1");
  end

  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [DWIDTH-1:0] r_dout;
  logic              r_dout_valid;
  logic              r_wr_err;
  logic              r_rd_err;

  logic              w_empty;
  logic              w_full;
  logic              w_rd_ok;
  logic              w_wr_ok;
  logic              w_ram_we;
  logic [DWIDTH-1:0] w_ram_rd;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_rd_ok = rd_en & ~w_empty;
  // A write into a full FIFO is legal when the head is popped on the same edge.
  assign w_wr_ok = wr_en & (~w_full | w_rd_ok);
  assign w_ram_we = w_wr_ok & ~rst;

  fifo_ram #(
    .DEPTH  (DEPTH),
    .DWIDTH (DWIDTH)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_ram_we),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (din),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_ram_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_wr_err     <= 1'b0;
      r_rd_err     <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
        r_dout   <= w_ram_rd;
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_dout_valid <= w_rd_ok;
      r_wr_err     <= wr_en & ~w_wr_ok;
      r_rd_err     <= rd_en & ~w_rd_ok;
    end
  end

  always_comb begin
    dout       = r_dout;
    dout_valid = r_dout_valid;
    if (FWFT_ON) begin
      dout       = w_empty ? '0 : w_ram_rd;
      dout_valid = ~w_empty;
    end
  end

  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_empty = (r_count <= AE_CNT);
  assign almost_full  = (r_count >= AF_CNT);
  assign count        = r_count;
  assign wr_err       = r_wr_err;
  assign rd_err       = r_rd_err;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench driving a standard-mode and an FWFT-mode FIFO in lockstep.
module tb_sync_fifo_flags;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] din = '0;

  logic [15:0] s_dout, f_dout;
  logic        s_dv, f_dv, s_empty, f_empty, s_full, f_full;
  logic        s_ae, f_ae, s_af, f_af, s_werr, f_werr, s_rerr, f_rerr;
  logic [3:0]  s_count, f_count;

  int n_checks = 0;
  int n_errs   = 0;

  logic [15:0] q[$];
  logic [15:0] m_std_dout;
  logic        m_std_dv, m_wr_err, m_rd_err;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DEPTH(8), .DWIDTH(16), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(s_dout), .dout_valid(s_dv), .empty(s_empty), .full(s_full),
    .almost_empty(s_ae), .almost_full(s_af), .count(s_count),
    .wr_err(s_werr), .rd_err(s_rerr)
  );

  sync_fifo_flags #(.DEPTH(8), .DWIDTH(16), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(f_dout), .dout_valid(f_dv), .empty(f_empty), .full(f_full),
    .almost_empty(f_ae), .almost_full(f_af), .count(f_count),
    .wr_err(f_werr), .rd_err(f_rerr)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // One clock with the given request; model updated per the accept rules.
  task automatic step(input logic w, input logic [15:0] d, input logic r);
    bit rok, wok;
    rok = r && (q.size() > 0);
    wok = w && ((q.size() < 8) || rok);
    wr_en = w; din = d; rd_en = r;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    if (rok) m_std_dout = q.pop_front();
    if (wok) q.push_back(d);
    m_std_dv = rok;
    m_wr_err = w && !wok;
    m_rd_err = r && !rok;
  endtask

  task automatic check_all(input string tag);
    int n;
    logic [15:0] head;
    n = q.size();
    head = (n > 0) ? q[0] : 16'h0000;
    chk({tag, ".s.count"}, s_count, n);
    chk({tag, ".f.count"}, f_count, n);
    chk({tag, ".s.empty"}, s_empty, n == 0);
    chk({tag, ".f.empty"}, f_empty, n == 0);
    chk({tag, ".s.full"},  s_full,  n == 8);
    chk({tag, ".f.full"},  f_full,  n == 8);
    chk({tag, ".s.ae"},    s_ae,    n <= 2);
    chk({tag, ".f.ae"},    f_ae,    n <= 2);
    chk({tag, ".s.af"},    s_af,    n >= 6);
    chk({tag, ".f.af"},    f_af,    n >= 6);
    chk({tag, ".s.werr"},  s_werr,  m_wr_err);
    chk({tag, ".f.werr"},  f_werr,  m_wr_err);
    chk({tag, ".s.rerr"},  s_rerr,  m_rd_err);
    chk({tag, ".f.rerr"},  f_rerr,  m_rd_err);
    chk({tag, ".s.dout"},  s_dout,  m_std_dout);
    chk({tag, ".s.dv"},    s_dv,    m_std_dv);
    chk({tag, ".f.dout"},  f_dout,  head);
    chk({tag, ".f.dv"},    f_dv,    n > 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset
    m_std_dout = '0; m_std_dv = 1'b0; m_wr_err = 1'b0; m_rd_err = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_all("reset");
    chk("reset.s.count0", s_count, 0);
    chk("reset.f.dout0", f_dout, 16'h0000);

    // Fill 0x0011..0x0088
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 16'h0011 * 16'(i + 1), 1'b0);
      check_all("fill");
      if (i == 1) chk("fill.ae_at2", s_ae, 1'b1);
      if (i == 2) chk("fill.ae_at3", s_ae, 1'b0);
      if (i == 4) chk("fill.af_at5", f_af, 1'b0);
      if (i == 5) chk("fill.af_at6", f_af, 1'b1);
    end
    chk("fill.full", s_full, 1'b1);
    chk("fill.f.head", f_dout, 16'h0011);

    step(1'b1, 16'h0099, 1'b0);
    check_all("ovf");
    chk("ovf.s.werr", s_werr, 1'b1);
    chk("ovf.f.count", f_count, 8);
    step(1'b0, '0, 1'b0);
    check_all("ovf.clear");
    chk("ovf.werr_pulse", s_werr, 1'b0);

    // Drain in order
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0, 1'b1);
      check_all("drain");
      chk("drain.s.word", s_dout, 16'h0011 * 16'(i + 1));
    end
    chk("drain.empty", f_empty, 1'b1);

    step(1'b0, '0, 1'b1);
    check_all("udf");
    chk("udf.s.rerr", s_rerr, 1'b1);
    chk("udf.s.dout_hold", s_dout, 16'h0088);
    chk("udf.f.rerr", f_rerr, 1'b1);
    step(1'b0, '0, 1'b0);
    check_all("udf.clear");

    // Simultaneous read+write while full
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 16'h0100 + 16'(i), 1'b0);
    end
    check_all("simfull.pre");
    step(1'b1, 16'h0200, 1'b1);
    check_all("simfull");
    chk("simfull.count", s_count, 8);
    chk("simfull.werr", f_werr, 1'b0);
    chk("simfull.s.dout", s_dout, 16'h0100);
    chk("simfull.f.head", f_dout, 16'h0101);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0, 1'b1);
      check_all("simfull.drain");
    end
    chk("simfull.last", s_dout, 16'h0200);

    // Simultaneous read+write while empty
    step(1'b1, 16'h0300, 1'b1);
    check_all("simempty");
    chk("simempty.count", f_count, 1);
    chk("simempty.rerr", s_rerr, 1'b1);
    chk("simempty.f.head", f_dout, 16'h0300);
    step(1'b0, '0, 1'b1);
    check_all("simempty.drain");

    // Wrap: occupancy cycles 3..5 across pointer wrap
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 16'h0400 + 16'(i), 1'b0);
    end
    check_all("wrap.pre");
    for (int i = 0; i < 20; i++) begin
      if ((i % 4) < 2) step(1'b1, 16'h0410 + 16'(i), 1'b0);
      else             step(1'b0, '0, 1'b1);
      check_all("wrap");
      chk("wrap.range", (s_count >= 4'd3) && (s_count <= 4'd5), 1'b1);
    end

    // Mid-operation reset with a concurrent write
    step(1'b1, 16'h0500, 1'b0);
    step(1'b1, 16'h0501, 1'b0);
    check_all("midrst.pre");
    chk("midrst.pre.count", s_count, 5);
    rst = 1'b1; wr_en = 1'b1; din = 16'hDEAD;
    @(posedge clk); #1;
    rst = 1'b0; wr_en = 1'b0;
    q.delete();
    m_std_dout = '0; m_std_dv = 1'b0; m_wr_err = 1'b0; m_rd_err = 1'b0;
    check_all("midrst");
    chk("midrst.count", f_count, 0);
    chk("midrst.s.dout", s_dout, 16'h0000);
    step(1'b1, 16'hBEEF, 1'b0);
    check_all("midrst.wr");
    step(1'b0, '0, 1'b1);
    check_all("midrst.rd");
    chk("midrst.beef", s_dout, 16'hBEEF);

    // Write-to-dout latency from empty
    step(1'b1, 16'h1234, 1'b0);
    check_all("lat");
    chk("lat.f.dout", f_dout, 16'h1234);
    chk("lat.f.dv", f_dv, 1'b1);
    chk("lat.s.hold", s_dout, 16'hBEEF);
    step(1'b0, '0, 1'b0);
    check_all("lat.idle");
    chk("lat.s.dv", s_dv, 1'b0);
    step(1'b0, '0, 1'b1);
    check_all("lat.rd");
    chk("lat.s.dout", s_dout, 16'h1234);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
